// File: rtl/ps2_key_event_queue_pkg.sv
// Shared types and lookups for the PS/2 key event queue: prefix bytes,
// parser states, queued event layout and the accepted-key tables.
package ps2_key_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
   localparam int         KEY_CODE_W     = 8;
   localparam int         KEY_EVENT_W    = KEY_CODE_W + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } parser_state_t;

   typedef struct packed {
      logic                  ext;
      logic                  brk;
      logic [KEY_CODE_W-1:0] code;
   } key_event_t;

   // F1-F5, digit row and ESC
   function automatic logic is_valid_key(input logic [KEY_CODE_W-1:0] code);
      case (code)
         8'h05, 8'h06, 8'h04, 8'h0C, 8'h03,
         8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
         8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
         8'h76:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Arrow keys, only meaningful after an E0 prefix
   function automatic logic is_valid_ext_key(input logic [KEY_CODE_W-1:0] code);
      case (code)
         8'h6B, 8'h74, 8'h75, 8'h72: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Byte-stream input and event-queue output bundle between the PS/2
// receiver / control processor (master) and the key event queue (slave).
interface ps2_key_event_queue_if #(
   parameter int DEPTH = 8
);
   import ps2_key_pkg::*;

   logic [KEY_CODE_W-1:0]      rx_data;
   logic                       rx_valid;
   logic                       pop;
   logic                       clr_overflow;
   logic [KEY_CODE_W-1:0]      ev_code;
   logic                       ev_ext;
   logic                       ev_break;
   logic                       interrupt;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       overflow;

   modport master (
      output rx_data, rx_valid, pop, clr_overflow,
      input  ev_code, ev_ext, ev_break, interrupt, count, overflow
   );

   modport slave (
      input  rx_data, rx_valid, pop, clr_overflow,
      output ev_code, ev_ext, ev_break, interrupt, count, overflow
   );

endinterface

// File: rtl/ps2_key_event_queue_fifo.sv
// Synchronous FIFO with combinational head read and simultaneous push/pop;
// a push into a full FIFO only lands when a pop frees the slot that cycle.
module key_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                       CLK_Nexys,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge CLK_Nexys) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is cleared on reset so the head fields read as zero afterwards
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge CLK_Nexys) begin
         if (reset)
            r_mem[gi] <= '0;
         else if (w_do_push && (r_wr_ptr == AW'(gi)))
            r_mem[gi] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser, accepted-key filter, typematic repeat suppression
// and event queue feeding the control processor.
module ps2_key_event_queue
   import ps2_key_pkg::*;
#(
   parameter int DEPTH         = 8,
   parameter int REPEAT_FILTER = 1,
   parameter int EXT_ENABLE    = 1
) (
   input  logic                 CLK_Nexys,
   input  logic                 reset,
   ps2_key_event_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH+1);

   parser_state_t         r_state;
   parser_state_t         w_state_next;
   logic                  w_final;
   logic                  w_fin_ext;
   logic                  w_fin_brk;
   logic                  w_accept;
   logic                  r_cand_valid;
   key_event_t            r_cand;
   logic                  r_held_valid;
   logic                  r_held_ext;
   logic [KEY_CODE_W-1:0] r_held_code;
   logic                  w_held_match;
   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   logic [CW-1:0]         w_count;
   key_event_t            w_head;
   logic                  r_overflow;
   logic                  w_ovf_set;

   always_ff @(posedge CLK_Nexys) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_final      = 1'b0;
      w_fin_ext    = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
      w_fin_brk    = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
      if (bus.rx_valid) begin
         if (bus.rx_data != PS2_PREFIX_EXT && bus.rx_data != PS2_PREFIX_BRK) begin
            w_final      = 1'b1;
            w_state_next = ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: w_state_next = (bus.rx_data == PS2_PREFIX_EXT) ? ST_EXT : ST_BRK;
               ST_EXT:  w_state_next = (bus.rx_data == PS2_PREFIX_EXT) ? ST_EXT : ST_EXT_BRK;
               ST_BRK:  w_state_next = (bus.rx_data == PS2_PREFIX_BRK) ? ST_BRK : ST_EXT_BRK;
               default: w_state_next = ST_EXT_BRK;
            endcase
         end
      end
   end

   assign w_accept = w_final && (w_fin_ext ? ((EXT_ENABLE != 0) && is_valid_ext_key(bus.rx_data))
                                           : is_valid_key(bus.rx_data));

   always_ff @(posedge CLK_Nexys) begin
      if (reset) begin
         r_cand_valid <= 1'b0;
         r_cand       <= '0;
      end else begin
         r_cand_valid <= w_accept;
         if (w_final) r_cand <= {w_fin_ext, w_fin_brk, bus.rx_data};
      end
   end

   // Second stage: repeat suppression against the currently held key
   assign w_held_match = r_held_valid && (r_held_ext == r_cand.ext) && (r_held_code == r_cand.code);
   assign w_push       = r_cand_valid && (r_cand.brk || !((REPEAT_FILTER != 0) && w_held_match));

   always_ff @(posedge CLK_Nexys) begin
      if (reset) begin
         r_held_valid <= 1'b0;
         r_held_ext   <= 1'b0;
         r_held_code  <= '0;
      end else if (r_cand_valid) begin
         if (!r_cand.brk && w_push) begin
            r_held_valid <= 1'b1;
            r_held_ext   <= r_cand.ext;
            r_held_code  <= r_cand.code;
         end else if (r_cand.brk && w_held_match) begin
            r_held_valid <= 1'b0;
         end
      end
   end

   key_event_fifo #(
      .WIDTH (KEY_EVENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK_Nexys (CLK_Nexys),
      .reset     (reset),
      .i_push    (w_push),
      .i_wdata   (r_cand),
      .i_pop     (bus.pop),
      .o_rdata   (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   // A full queue is never empty, so a pop there always frees a slot
   assign w_ovf_set = w_push && w_full && !bus.pop;

   always_ff @(posedge CLK_Nexys) begin
      if (reset)                 r_overflow <= 1'b0;
      else if (w_ovf_set)        r_overflow <= 1'b1;
      else if (bus.clr_overflow) r_overflow <= 1'b0;
   end

   assign bus.ev_code   = w_head.code;
   assign bus.ev_ext    = w_head.ext;
   assign bus.ev_break  = w_head.brk;
   assign bus.interrupt = !w_empty;
   assign bus.count     = w_count;
   assign bus.overflow  = r_overflow;

endmodule
